program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/simple_pkg.sv | 25 ++
 rtl/loader_checksum.sv | 25 ++
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared types for the program loader: FSM state encoding and datapath widths.
// Checksum support is selected at build time with LOADER_CHECKSUM_EN.
package simple_pkg;

  localparam int WORD_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } state_e;

  function automatic logic takes_byte(state_e s);
    return (s == LEN_HI) || (s == LEN_LO) ||
           (s == DATA_HI) || (s == DATA_LO) ||
           (s == CSUM);
  endfunction

endpackage

// File: rtl/loader_checksum.sv
// Running 8-bit modular sum of payload bytes.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_checksum
  import simple_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  add_en_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic [BYTE_WIDTH-1:0] sum_o
);

  logic [BYTE_WIDTH-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + byte_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: length header, big-endian words, optional CSUM.
// Define LOADER_CHECKSUM_EN to require a trailing 8-bit payload checksum.
module program_loader
  import simple_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR = 16'h0000,
  parameter int                    MAX_WORDS = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [BYTE_WIDTH-1:0] rx_byte,
  output logic                  rx_ready,
  output logic [WORD_WIDTH-1:0] memoryAddress,
  output logic [WORD_WIDTH-1:0] memoryWriteData,
  output logic                  memoryWriteEnable,
  output logic                  cpu_run,
  output logic                  load_error,
  output logic [WORD_WIDTH-1:0] loaded_count
);

  localparam logic [WORD_WIDTH:0] MAX_W = (WORD_WIDTH+1)'(MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  localparam state_e END_ST = CSUM;
`else
  localparam state_e END_ST = DONE;
`endif

  state_e                state_q, state_d;
  logic                  rdy_q;
  logic                  we_q;
  logic                  run_q;
  logic                  err_q;
  logic [WORD_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic [WORD_WIDTH-1:0] cnt_q;
  logic [WORD_WIDTH-1:0] len_q;
  logic [WORD_WIDTH-1:0] idx_q;
  logic [BYTE_WIDTH-1:0] hi_q;

  logic                  acc;
  logic [WORD_WIDTH-1:0] len_full;
  logic [WORD_WIDTH-1:0] idx_inc;

  assign acc      = rx_valid && rdy_q;
  assign len_full = {len_q[WORD_WIDTH-1:BYTE_WIDTH], rx_byte};
  assign idx_inc  = idx_q + 16'd1;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum;
  logic                  csum_add;

  assign csum_add = acc && ((state_q == DATA_HI) ||
                            (state_q == DATA_LO));

  loader_checksum u_csum (
    .clock    (clock),
    .reset    (reset),
    .add_en_i (csum_add),
    .byte_i   (rx_byte),
    .sum_o    (csum)
  );
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_HI:  if (acc) state_d = LEN_LO;
      LEN_LO: begin
        if (acc) begin
          if ({1'b0, len_full} > MAX_W) state_d = ERROR;
          else if (len_full == '0)     state_d = END_ST;
          else                         state_d = DATA_HI;
        end
      end
      DATA_HI: if (acc) state_d = DATA_LO;
      DATA_LO: if (acc) state_d = WRITE;
      WRITE:   state_d = (idx_inc == len_q) ? END_ST : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
      CSUM:    if (acc) state_d = (rx_byte == csum) ? DONE : ERROR;
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = ERROR;
    endcase
  end

  // Status outputs are derived from the next state so they are registered
  // yet line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LEN_HI;
      rdy_q   <= 1'b1;
      we_q    <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= takes_byte(state_d);
      we_q    <= (state_d == WRITE);
      run_q   <= (state_d == DONE);
      err_q   <= (state_d == ERROR);
      unique case (state_q)
        LEN_HI: if (acc) len_q[WORD_WIDTH-1:BYTE_WIDTH] <= rx_byte;
        LEN_LO: begin
          if (acc) begin
            len_q <= len_full;
            idx_q <= '0;
          end
        end
        DATA_HI: if (acc) hi_q <= rx_byte;
        DATA_LO: begin
          if (acc) begin
            data_q <= {hi_q, rx_byte};
            addr_q <= BASE_ADDR + idx_q;
          end
        end
        WRITE: begin
          idx_q <= idx_inc;
          cnt_q <= cnt_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready          = rdy_q;
  assign memoryAddress     = addr_q;
  assign memoryWriteData   = data_q;
  assign memoryWriteEnable = we_q;
  assign cpu_run           = run_q;
  assign load_error        = err_q;
  assign loaded_count      = cnt_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and popped by a monitor whenever the write strobe is seen.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic [15:0] memoryAddress;
  logic [15:0] memoryWriteData;
  logic        memoryWriteEnable;
  logic        cpu_run;
  logic        load_error;
  logic [15:0] loaded_count;

  program_loader dut (
    .clock             (clock),
    .reset             (reset),
    .rx_valid          (rx_valid),
    .rx_byte           (rx_byte),
    .rx_ready          (rx_ready),
    .memoryAddress     (memoryAddress),
    .memoryWriteData   (memoryWriteData),
    .memoryWriteEnable (memoryWriteEnable),
    .cpu_run           (cpu_run),
    .load_error        (load_error),
    .loaded_count      (loaded_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic send(logic [7:0] b);
    int n;
    n = 0;
    rx_byte  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!rx_ready) begin
      check("send_timeout", 32'(rx_ready), 32'd1);
      return;
    end
    @(negedge clock);
  endtask

  task automatic idle(int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    reset    = 1'b0;
  endtask

  task automatic push_frame_a();
    wr_t w;
    w.a = 16'h0000; w.d = 16'h1234; exp_q.push_back(w);
    w.a = 16'h0001; w.d = 16'hABCD; exp_q.push_back(w);
  endtask

  task automatic send_frame_a();
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34);
    send(8'hAB); send(8'hCD);
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (memoryWriteEnable === 1'b1) begin
      check("rx_ready_in_write", 32'(rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(memoryAddress), 32'(e.a));
        check("wr_data", 32'(memoryWriteData), 32'(e.d));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_we", 32'(memoryWriteEnable), 32'd0);
    check("rst_addr", 32'(memoryAddress), 32'h0000);
    check("rst_data", 32'(memoryWriteData), 32'h0000);
    check("rst_run", 32'(cpu_run), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    check("rst_count", 32'(loaded_count), 32'd0);
    reset = 1'b0;

    // Two-word frame with rx_valid held high throughout.
    push_frame_a();
    send_frame_a();
`ifdef LOADER_CHECKSUM_EN
    send(8'hBE);
`endif
    idle(3);
    check("a_run", 32'(cpu_run), 32'd1);
    check("a_count", 32'(loaded_count), 32'd2);
    check("a_err", 32'(load_error), 32'd0);
    check("a_rx_ready", 32'(rx_ready), 32'd0);
    check("a_drained", 32'(exp_q.size()), 32'd0);

    // Zero-length frame.
    do_reset();
    send(8'h00);
    send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    check("z_run", 32'(cpu_run), 32'd1);
    idle(2);
    check("z_count", 32'(loaded_count), 32'd0);

    // Length 257 exceeds MAX_WORDS.
    do_reset();
    send(8'h01);
    send(8'h01);
    check("big_err", 32'(load_error), 32'd1);
    check("big_rx_ready", 32'(rx_ready), 32'd0);
    rx_byte  = 8'h55;
    rx_valid = 1'b1;
    repeat (4) @(negedge clock);
    check("big_stuck_ready", 32'(rx_ready), 32'd0);
    check("big_stuck_err", 32'(load_error), 32'd1);
    check("big_run", 32'(cpu_run), 32'd0);
    check("big_count", 32'(loaded_count), 32'd0);

    // Length exactly MAX_WORDS is accepted.
    do_reset();
    send(8'h01);
    send(8'h00);
    check("max_err", 32'(load_error), 32'd0);
    check("max_rx_ready", 32'(rx_ready), 32'd1);

    // Abort mid-frame, then resend.
    do_reset();
    send(8'h00);
    send(8'h02);
    send(8'h12);
    do_reset();
    check("ab_count", 32'(loaded_count), 32'd0);
    check("ab_rx_ready", 32'(rx_ready), 32'd1);
    push_frame_a();
    send_frame_a();
`ifdef LOADER_CHECKSUM_EN
    send(8'hBE);
`endif
    idle(3);
    check("ab2_count", 32'(loaded_count), 32'd2);
    check("ab2_run", 32'(cpu_run), 32'd1);
    check("ab2_drained", 32'(exp_q.size()), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    push_frame_a();
    send_frame_a();
    send(8'hBF);
    idle(3);
    check("cs_err", 32'(load_error), 32'd1);
    check("cs_run", 32'(cpu_run), 32'd0);
    check("cs_count", 32'(loaded_count), 32'd2);
    check("cs_drained", 32'(exp_q.size()), 32'd0);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
